chunked_add_ctrl: RTL and testbench
===================================

# chunked_add_ctrl

Multi-cycle wide-add sequencer. It computes a WIDTH-bit sum by time-sharing a single CHUNK-wide ripple-carry adder across WIDTH/CHUNK consecutive cycles, carrying between chunks in a register. It sits between operand producers and result consumers as a low-area alternative to a full-width ripple adder, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 128, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 32, adder slice width processed per cycle; CHUNK >= 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to chunk 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out of the top chunk.

## Operation
- Derived: N = WIDTH/CHUNK chunks; chunk index k in range 0..N-1, slice [k*CHUNK +: CHUNK].
- One CHUNK-wide ripple-carry adder instance, the team's ripple_crry_adder with MaxSize=CHUNK. It is fed the current operand slices and the carry register.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready, latch a, b, and cin into the carry register; clear chunk counter k=0; go to RUN.
  - RUN: each cycle, add slice k of latched A/B plus the carry register. Write the slice result into sum[k*CHUNK +: CHUNK] and the adder carry-out into the carry register, then increment k. When k==N-1, also load cout from the adder carry-out and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Operands are captured only at accept. Input changes afterwards are ignored.
- sum and cout hold their value after DONE→IDLE until the next accepted request overwrites them chunk by chunk. Partially updated sum during RUN is not valid.
- Unsigned modular arithmetic: sum = (A + B + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored, not queued.
- Reset (any time, including mid-RUN): state→IDLE, k→0, carry register→0, sum→0, cout→0, out_valid→0. in_ready is forced 0 while rst is high and returns to 1 in the first cycle after rst deasserts.

## Timing
- Accept at edge E0 (in_valid&&in_ready high in the cycle ending at E0).
- RUN occupies N cycles; chunk k is written at edge E0+1+k.
- out_valid is high from the cycle after edge E0+N. For defaults N=4, out_valid rises 4 edges after accept.
- Completion occurs at the first edge with out_valid&&out_ready. in_ready is 1 the following cycle.
- Minimum request spacing: N+2 cycles (accept, N RUN, one DONE cycle with out_ready=1).
- out_valid, sum, and cout are stable for as long as out_ready is held low.
- N=1 (CHUNK==WIDTH): a single RUN cycle; behaviour otherwise identical.

## Configuration
- CHUNKED_ADD_SUB_EN defined: adds port `sub` (input, 1 bit), latched at accept together with the operands.
  - When sub=1, latched B is stored inverted and the carry register is initialised to 1, ignoring cin. The result is sum = A − B mod 2^WIDTH, with cout=1 meaning no borrow.
  - When sub=0, behaviour is identical to the add-only build.
- Macro undefined: no `sub` port; add only.

## Test plan
- Reset: hold rst 3 cycles, then release. During reset sum=0, cout=0, out_valid=0, and in_ready=0. in_ready=1 in the first cycle after release.
- Full carry chain: a=all ones, b=0, cin=1 → sum=0, cout=1. out_valid rises exactly 4 edges after accept (defaults).
- Inter-chunk carry: a=0x0000…0000_FFFFFFFF, b=1, cin=0 → sum=0x1_00000000, cout=0. Also a=2^96−1, b=2^96−1 → sum=2^97−2, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and drive in_valid=1 with new operands throughout.
  - out_valid, sum, and cout stay stable, and in_ready stays 0.
  - After out_ready=1 for one cycle, the next request is accepted and the earlier ignored operands produce no result.
- Reset mid-operation: assert rst during the second RUN cycle → immediately state IDLE, out_valid=0, sum=0. A subsequent request (a=5, b=7) returns sum=12 with normal latency.
- CHUNKED_ADD_SUB_EN build: sub=1, a=5, b=7 → sum=2^128−2, cout=0. sub=1, a=7, b=5 → sum=2, cout=1.

Source files
------------

// File: rtl/chunked_add_ctrl.sv
// Multi-cycle wide adder: one CHUNK-wide ripple adder is reused over WIDTH/CHUNK cycles.
// Optional subtract mode (extra `sub` port) is enabled by defining CHUNKED_ADD_SUB_EN.

module ripple_crry_adder #(
  parameter int MaxSize = 32
) (
  input  logic [MaxSize-1:0] a_i,
  input  logic [MaxSize-1:0] b_i,
  input  logic               c_i,
  output logic [MaxSize-1:0] s_o,
  output logic               c_o
);

  always_comb begin
    logic c;
    c   = c_i;
    s_o = '0;
    for (int i = 0; i < MaxSize; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    c_o = c;
  end

endmodule

module chunked_add_ctrl #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [CHUNK-1:0] add_a, add_b, add_s;
  logic             add_c;
  logic             accept;
  logic             sub_en;

`ifdef CHUNKED_ADD_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        add_a = a_q[i*CHUNK +: CHUNK];
        add_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  ripple_crry_adder #(
    .MaxSize(CHUNK)
  ) u_adder (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Subtraction is A + ~B + 1; cin is ignored in that mode.
          a_d     = a;
          b_d     = sub_en ? ~b : b;
          carry_d = sub_en ? 1'b1 : cin;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) sum_d[i*CHUNK +: CHUNK] = add_s;
        end
        carry_d = add_c;
        if (k_q == KW'(N - 1)) begin
          cout_d  = add_c;
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Latched operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule

// File: tb/tb_chunked_add_ctrl.sv
// Scoreboard bench for chunked_add_ctrl: directed requests push expected results,
// a negedge monitor pops and compares on every out_valid&&out_ready handshake.

module tb_chunked_add_ctrl;

  localparam int WIDTH = 128;
  localparam int CHUNK = 32;

  typedef logic [WIDTH:0] val_t;
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CHUNKED_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chunked_add_ctrl #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNKED_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic chk(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %h cout %b with no pending request", sum, cout);
      end else begin
        e = q.pop_front();
        chk("result_sum", val_t'(sum), val_t'(e.s));
        chk("result_cout", val_t'(cout), val_t'(e.c));
      end
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_out_valid(input bit check_lat);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (check_lat) chk("latency", val_t'(n), val_t'(4));
    else if (!out_valid) chk("out_valid_timeout", val_t'(out_valid), val_t'(1));
  endtask

  // Issue one request with out_ready held high and wait for it to complete.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                      input logic tc, input logic [WIDTH-1:0] es, input logic ec);
    exp_t e;
    a = ta;
    b = tb_v;
    cin = tc;
    in_valid = 1'b1;
    wait_in_ready();
    e.s = es;
    e.c = ec;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] ones96;
    logic [WIDTH-1:0] exp96;
    logic [WIDTH-1:0] bp_sum;
    exp_t e;
    ones96 = {32'h0, {96{1'b1}}};
    exp96  = {31'h0, {96{1'b1}}, 1'b0};
    bp_sum = 128'h0000_0001_0000_0002_0000_0003_0000_0004 + 128'h0000_0010_0000_0020_0000_0030_0000_0040;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef CHUNKED_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("reset_sum", val_t'(sum), val_t'(0));
    chk("reset_cout", val_t'(cout), val_t'(0));
    chk("reset_out_valid", val_t'(out_valid), val_t'(0));
    chk("reset_in_ready", val_t'(in_ready), val_t'(0));
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", val_t'(in_ready), val_t'(1));

    send('1, '0, 1'b1, '0, 1'b1);
    send(128'hFFFF_FFFF, 128'h1, 1'b0, 128'h1_0000_0000, 1'b0);
    send(ones96, ones96, 1'b0, exp96, 1'b0);
    send('1, '1, 1'b1, '1, 1'b1);
    send(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
         1'b0, '0, 1'b1);
    send(128'h1234, 128'h4321, 1'b1, 128'h5556, 1'b0);

    // Backpressure: new operands are held on the input while the result stalls.
    a = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
    b = 128'h0000_0010_0000_0020_0000_0030_0000_0040;
    cin = 1'b0;
    in_valid = 1'b1;
    wait_in_ready();
    e.s = bp_sum;
    e.c = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
    a = 128'hDEAD_BEEF;
    b = 128'hCAFE;
    cin = 1'b1;
    out_ready = 1'b0;
    wait_out_valid(1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", val_t'(out_valid), val_t'(1));
      chk("bp_sum_stable", val_t'(sum), val_t'(bp_sum));
      chk("bp_cout_stable", val_t'(cout), val_t'(0));
      chk("bp_in_ready", val_t'(in_ready), val_t'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_done", val_t'(in_ready), val_t'(1));
    a = 128'd3;
    b = 128'd4;
    cin = 1'b0;
    e.s = 128'd7;
    e.c = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(1'b1);
    @(posedge clk); #1;

    // Reset during the second RUN cycle aborts the request without a result.
    a = '1;
    b = 128'd9;
    cin = 1'b0;
    in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrun_out_valid", val_t'(out_valid), val_t'(0));
    chk("midrun_sum", val_t'(sum), val_t'(0));
    chk("midrun_cout", val_t'(cout), val_t'(0));
    chk("midrun_in_ready", val_t'(in_ready), val_t'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrun_in_ready_release", val_t'(in_ready), val_t'(1));
    send(128'd5, 128'd7, 1'b0, 128'd12, 1'b0);

`ifdef CHUNKED_ADD_SUB_EN
    sub = 1'b1;
    send(128'd5, 128'd7, 1'b0, {{127{1'b1}}, 1'b0}, 1'b0);
    send(128'd7, 128'd5, 1'b0, 128'd2, 1'b1);
    sub = 1'b0;
    send(128'd7, 128'd5, 1'b1, 128'd13, 1'b0);
`endif

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", val_t'(q.size()), val_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
